// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared constants and helpers for the FFT output reorder buffer.
//   DEFAULT_DATA_WIDTH : default sample word width
//   DEFAULT_N_POINT    : default frame length (power of two, >= 4)
//   ADDR_W             : address width for a default-sized bank
//   bitrev()           : reverses the low 'width' bits of an index
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_N_POINT    = 16;
  localparam int ADDR_W             = $clog2(DEFAULT_N_POINT);

  // Reverse all 32 bits, then shift the reversed field back down so only the
  // low 'width' bits of the original index are mirrored.
  function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
    logic [31:0] rev;
    rev = {<<{val}};
    return rev >> (32 - width);
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// -----------------------------------------------------------------------------
// fft_reorder_bank
//   One ping-pong bank: 2**ADDR_W words of DATA_WIDTH bits, one synchronous
//   write port and one combinational read port.
//   clk     : clock, rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from the register array)
// -----------------------------------------------------------------------------
module fft_reorder_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the owner's full flags decide whether an
  // entry is meaningful, so clearing storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_output_reorder.sv
// -----------------------------------------------------------------------------
// fft_output_reorder
//   Converts bit-reversed FFT output frames into natural index order using two
//   ping-pong banks. Samples are written at bitrev(k) and read out linearly.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : input handshake
//   in_data, in_last    : input sample and upstream end-of-frame marker
//   out_valid/out_ready : output handshake
//   out_data, out_last  : natural-order sample, high on index N_POINT-1
//   err_last            : pulses when in_last disagrees with the write counter
// -----------------------------------------------------------------------------
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N_POINT    = DEFAULT_N_POINT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  err_last
);

  // Address width follows the instance's N_POINT, not the package default.
  localparam int           AW       = $clog2(N_POINT);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINT - 1);

  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;

  logic                  in_acc, out_acc;
  logic                  wr_at_last, rd_at_last;
  logic [AW-1:0]         waddr;
  logic [DATA_WIDTH-1:0] rdata [2];

  // Handshake outputs come from registered flags only, so no combinational
  // path exists from in_valid/out_ready to the ready/valid outputs.
  assign in_ready   = ~full_q[wr_bank_q];
  assign out_valid  = full_q[rd_bank_q];
  assign in_acc     = in_valid & in_ready;
  assign out_acc    = out_valid & out_ready;
  assign wr_at_last = (wr_cnt_q == LAST_IDX);
  assign rd_at_last = (rd_cnt_q == LAST_IDX);

  assign waddr    = AW'(bitrev(32'(wr_cnt_q), AW));
  assign out_data = rdata[rd_bank_q];
  assign out_last = out_valid & rd_at_last;
  assign err_last = in_acc & (in_last ^ wr_at_last);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_W    (AW)
    ) u_bank (
      .clk    (clk),
      .we_i   (in_acc && (wr_bank_q == 1'(b))),
      .waddr_i(waddr),
      .wdata_i(in_data),
      .raddr_i(rd_cnt_q),
      .rdata_o(rdata[b])
    );
  end

  // NOTE: every next-state signal is given its hold value first so no path
  // through this block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;

    if (in_acc) begin
      if (wr_at_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end

    // A write can only target an empty bank and a read only a full one, so the
    // two updates above and below never touch the same flag in one cycle.
    if (out_acc) begin
      if (rd_at_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + AW'(1);
      end
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_output_reorder
//   Directed bench for an 8-point reorder buffer. Inputs change just after a
//   rising edge; outputs are sampled 1 time unit later, well before the next
//   edge. Expected natural-order sequence for inputs k = 0..7 is the
//   bit-reversed index table 0,4,2,6,1,5,3,7 plus a per-frame base.
// -----------------------------------------------------------------------------
module tb_fft_output_reorder;

  localparam int DW = 16;
  localparam int NP = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          err_last;

  int n_checks;
  int n_errors;
  int exp_order [NP] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_output_reorder #(
    .DATA_WIDTH(DW),
    .N_POINT   (NP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .err_last (err_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_last", err_last, 0);
  endtask

  // Expects one complete frame to leave on consecutive cycles, out_ready high.
  task automatic drain_frame(input string tag, input logic [DW-1:0] base);
    for (int n = 0; n < NP; n++) begin
      #1;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, 32'(base) + 32'(exp_order[n]));
      check({tag, "_last"}, out_last, (n == NP - 1));
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Single frame, back-to-back, first out_valid right after the 8th accept.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < NP; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(k);
      in_last  = (k == NP - 1);
      #1;
      check("t1_in_ready", in_ready, 1);
      check("t1_no_early_valid", out_valid, 0);
      check("t1_err", err_last, 0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain_frame("t1", 16'h0000);
    #1;
    check("t1_idle", out_valid, 0);

    // Four frames streamed continuously: no input stall, no output gaps.
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c <= 4 * NP + NP; c++) begin
      in_valid = (c < 4 * NP);
      in_data  = DW'(16'h1000 + c);
      in_last  = (c < 4 * NP) && (c % NP == NP - 1);
      #1;
      if (c < 4 * NP) begin
        check("t2_in_ready", in_ready, 1);
        check("t2_err", err_last, 0);
      end
      if (c >= NP && c < 5 * NP) begin
        check("t2_valid", out_valid, 1);
        check("t2_data", out_data,
              32'h1000 + 32'(NP * ((c - NP) / NP)) + 32'(exp_order[(c - NP) % NP]));
        check("t2_last", out_last, ((c - NP) % NP == NP - 1));
      end else begin
        check("t2_gap", out_valid, 0);
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Backpressure: fill both banks, hold, then drain.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 2 * NP; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h2000 + c);
      in_last  = (c % NP == NP - 1);
      #1;
      check("t3_fill_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b1;
    in_data  = 16'hdead;
    in_last  = 1'b0;
    for (int h = 0; h < 3; h++) begin
      #1;
      check("t3_hold_ready", in_ready, 0);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_data", out_data, 32'h2000);
      check("t3_hold_last", out_last, 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 2 * NP; d++) begin
      #1;
      check("t3_drain_ready", in_ready, (d >= NP));
      check("t3_drain_valid", out_valid, 1);
      check("t3_drain_data", out_data,
            32'h2000 + 32'(NP * (d / NP)) + 32'(exp_order[d % NP]));
      check("t3_drain_last", out_last, (d % NP == NP - 1));
      step();
    end
    #1;
    check("t3_empty", out_valid, 0);

    // in_last on the wrong beat: errors flagged, framing unaffected.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < NP; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h3000 + k);
      in_last  = (k == 3);
      #1;
      check("t4_err_last", err_last, (k == 3 || k == NP - 1));
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain_frame("t4", 16'h3000);
    #1;
    check("t4_err_idle", err_last, 0);

    // Reset mid-frame with one full frame pending.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < NP + 5; c++) begin
      in_valid = 1'b1;
      in_data  = (c < NP) ? DW'(16'h4000 + c) : DW'(16'h5000 + c - NP);
      in_last  = (c == NP - 1);
      #1;
      check("t5_pre_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check("t5_pending", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ready", in_ready, 1);
    check("t5_rst_last", out_last, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < NP; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h6000 + k);
      in_last  = (k == NP - 1);
      #1;
      check("t5_post_valid", out_valid, 0);
      check("t5_post_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain_frame("t5", 16'h6000);
    #1;
    check("t5_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_output_reorder.md
FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one sample word.
REQ-002 SHALL have parameter N_POINT, default 16: frame length; must be a power of two and at least 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream FFT sample valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-007 SHALL have port in_data, input, DATA_WIDTH bits: FFT result sample, arriving in bit-reversed index order.
REQ-008 SHALL have port in_last, input, 1 bit: upstream end-of-frame marker.
REQ-009 SHALL have port out_valid, output, 1 bit: natural-order sample valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream can accept a sample.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits: sample in natural index order.
REQ-012 SHALL have port out_last, output, 1 bit: high on the final sample (index N_POINT-1) of an output frame.
REQ-013 SHALL have port err_last, output, 1 bit: one-cycle pulse on an in_last framing mismatch.

Function
REQ-014 SHALL transfer an input sample only when in_valid and in_ready are both high; SHALL transfer an output sample only when out_valid and out_ready are both high.
REQ-015 SHALL hold two N_POINT-entry banks (ping-pong), each with a registered full flag.
REQ-016 SHALL write accepted input k (k = 0..N_POINT-1, counted by a write counter) into the current write bank at address bitrev(k), where bitrev reverses the log2(N_POINT) address bits.
REQ-017 SHALL, on the accept with k = N_POINT-1, set that bank's full flag, toggle the write bank, and wrap the write counter to 0.
REQ-018 SHALL drive in_ready = NOT full flag of the current write bank, using registered state only.
REQ-019 SHALL drive out_valid = full flag of the current read bank, and out_data = entry [read counter] of the read bank (combinational read of the registered array).
REQ-020 SHALL, on the output accept with read counter = N_POINT-1, clear that bank's full flag, toggle the read bank, and wrap the read counter to 0.
REQ-021 SHALL assert out_valid for the first output sample in the cycle after the N_POINT-th input accept (latency: 1 cycle after frame completion).
REQ-022 SHALL sustain one sample per cycle on both sides when in_valid and out_ready are held high; there are no bubbles between frames.
REQ-023 SHALL make a bank freed by the final read usable by the writer starting the next cycle; in the freeing cycle itself, in_ready stays low.
REQ-024 SHALL hold out_data, out_last and out_valid stable while out_valid is high and out_ready is low.
REQ-025 SHALL ignore in_last for framing (the write counter alone defines frame boundaries).
REQ-026 SHALL pulse err_last for one cycle on an accept where in_last differs from (k = N_POINT-1).
REQ-027 SHALL, when both banks are full, hold in_ready low indefinitely without losing data.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously clear both full flags, both counters, and both bank selects (write bank 0, read bank 0); the block SHALL then show in_ready=1, out_valid=0, out_last=0, err_last=0.
REQ-029 SHALL, on reset mid-frame, discard all buffered and partial frames; bank contents need no reset.

Structure
REQ-030 SHALL take DATA_WIDTH/N_POINT defaults, the localparam ADDR_W = log2(N_POINT), and a bitrev function from shared package fft_pkg.
REQ-031 SHALL implement each bank as one instance of sub-module fft_reorder_bank (N_POINT x DATA_WIDTH registers, one write port, one combinational read port), instantiated twice.

Verification
REQ-032 With N_POINT=8, in_data=0..7 streamed back-to-back and out_ready=1 -> out_data sequence is 0,4,2,6,1,5,3,7, out_last high on the 8th sample only, and first out_valid appears one cycle after the 8th accept.
REQ-033 Four frames streamed continuously with out_ready=1 -> in_ready never drops and outputs are gap-free, each frame reordered correctly.
REQ-034 out_ready=0 while two frames are written -> in_ready goes low after the 16th accept; out_data is held stable; raising out_ready drains both frames in order; in_ready rises the cycle after the first frame's final read.
REQ-035 in_last asserted on k=3 and absent on k=7 -> two err_last pulses, and the output frame is still correctly reordered.
REQ-036 rst_n pulsed low after 5 inputs of a frame, with one full frame pending -> out_valid=0 and in_ready=1 immediately; the next 8 inputs form a clean frame with correct order.
